// File: rtl/ram_datos_ctrl_if.sv
// ram_datos_ctrl_if
//  Request/response bundle between the pipeline (MEM stage + debug unit) and
//  the data BRAM controller. Names are from the controller's point of view:
//  i_* are driven by the requesters, o_* by the controller.
//  MEM:   i_mem_req/we/size/unsigned/addr/wdata -> o_mem_rdata/done/err/stall
//  Debug: i_dbg_req/addr                        -> o_dbg_rdata/done
interface ram_datos_ctrl_if;
    logic        i_mem_req;
    logic        i_mem_we;
    logic [1:0]  i_mem_size;
    logic        i_mem_unsigned;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic [31:0] o_mem_rdata;
    logic        o_mem_done;
    logic        o_mem_err;
    logic        o_mem_stall;
    logic        i_dbg_req;
    logic [31:0] i_dbg_addr;
    logic [31:0] o_dbg_rdata;
    logic        o_dbg_done;

    modport slave (
        input  i_mem_req, i_mem_we, i_mem_size, i_mem_unsigned, i_mem_addr, i_mem_wdata,
        output o_mem_rdata, o_mem_done, o_mem_err, o_mem_stall,
        input  i_dbg_req, i_dbg_addr,
        output o_dbg_rdata, o_dbg_done
    );

    modport master (
        output i_mem_req, i_mem_we, i_mem_size, i_mem_unsigned, i_mem_addr, i_mem_wdata,
        input  o_mem_rdata, o_mem_done, o_mem_err, o_mem_stall,
        output i_dbg_req, i_dbg_addr,
        input  o_dbg_rdata, o_dbg_done
    );
endinterface

// File: rtl/ram_datos_ctrl.sv
// ram_datos_ctrl
//  Access controller for the single-port data BRAM (2-cycle read latency with
//  output register). Arbitrates MEM stage (fixed priority) against the debug
//  unit, stalls MEM during reads, and does sb/sh as read-modify-write.
//  Ports:
//   i_clka, i_rsta       clock, synchronous active-high reset
//   bus (slave)          MEM and debug request/response bundle
//   o_ram_addr/din/we    BRAM word index, write data, write enable
//   o_ram_en/regce/rst   BRAM read enable, output register enable, reset
//   i_ram_dout           BRAM read data (valid 2 cycles after o_ram_en)
//  Byte lanes are little-endian; the lane logic assumes a 32-bit word.
module ram_datos_ctrl #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 2048
) (
    input  logic                 i_clka,
    input  logic                 i_rsta,
    ram_datos_ctrl_if.slave      bus,
    output logic [RAM_WIDTH-1:0] o_ram_addr,
    output logic [RAM_WIDTH-1:0] o_ram_din,
    output logic                 o_ram_we,
    output logic                 o_ram_en,
    output logic                 o_ram_regce,
    output logic                 o_ram_rst,
    input  logic [RAM_WIDTH-1:0] i_ram_dout
);

    typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_WR, S_DONE} state_t;

    state_t                 r_state, w_next_state;
    logic                   r_owner_dbg;   // 1 = current access belongs to debug
    logic                   r_we;
    logic [1:0]             r_size;
    logic                   r_unsigned;
    logic [1:0]             r_lane;
    logic [RAM_WIDTH-1:0]   r_idx;
    logic [RAM_WIDTH-1:0]   r_wdata;       // store data, replaced by merged word in RD2
    logic                   r_err;
    logic [RAM_WIDTH-1:0]   r_mem_rdata;
    logic [RAM_WIDTH-1:0]   r_dbg_rdata;

    logic [RAM_WIDTH-1:0]   w_mem_idx;
    logic                   w_mem_err;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [RAM_WIDTH-1:0]   w_load;
    logic [RAM_WIDTH-1:0]   w_merged;
    logic                   w_mem_done;

    // Request decode for the grant decision in IDLE
    always_comb begin
        w_mem_idx = {2'b00, bus.i_mem_addr[RAM_WIDTH-1:2]};
        w_mem_err = (bus.i_mem_size == 2'b11)
                  | ((bus.i_mem_size == 2'b01) & bus.i_mem_addr[0])
                  | ((bus.i_mem_size == 2'b10) & (bus.i_mem_addr[1:0] != 2'b00))
                  | (w_mem_idx >= 32'(RAM_DEPTH));
    end

    // Lane extraction / extension for loads, lane insertion for sub-word stores
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = i_ram_dout[7:0];
            2'd1:    w_byte = i_ram_dout[15:8];
            2'd2:    w_byte = i_ram_dout[23:16];
            default: w_byte = i_ram_dout[31:24];
        endcase
        w_half = r_lane[1] ? i_ram_dout[31:16] : i_ram_dout[15:0];
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = i_ram_dout;
        endcase

        w_merged = i_ram_dout;
        if (r_size == 2'b00) begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            w_merged[15:0]  = r_wdata[15:0];
        end
    end

    // Next state and BRAM/handshake outputs
    always_comb begin
        w_next_state   = r_state;
        o_ram_addr     = '0;
        o_ram_din      = '0;
        o_ram_we       = 1'b0;
        o_ram_en       = 1'b0;
        o_ram_regce    = 1'b0;
        w_mem_done     = 1'b0;
        bus.o_mem_err  = 1'b0;
        bus.o_dbg_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_mem_req) begin
                    if (w_mem_err) begin
                        w_next_state = S_DONE;
                    end else if (bus.i_mem_we && (bus.i_mem_size == 2'b10)) begin
                        // full-word store goes straight to the BRAM
                        w_next_state = S_DONE;
                        o_ram_addr   = w_mem_idx;
                        o_ram_din    = bus.i_mem_wdata;
                        o_ram_we     = 1'b1;
                    end else begin
                        // load, or first half of a sub-word read-modify-write
                        w_next_state = S_RD1;
                        o_ram_addr   = w_mem_idx;
                        o_ram_en     = 1'b1;
                    end
                end else if (bus.i_dbg_req) begin
                    w_next_state = S_RD1;
                    o_ram_addr   = bus.i_dbg_addr;
                    o_ram_en     = 1'b1;
                end
            end
            S_RD1: begin
                w_next_state = S_RD2;
                o_ram_addr   = r_idx;
                o_ram_regce  = 1'b1;
            end
            S_RD2: begin
                w_next_state = (!r_owner_dbg && r_we) ? S_WR : S_DONE;
                o_ram_addr   = r_idx;
            end
            S_WR: begin
                w_next_state = S_DONE;
                o_ram_addr   = r_idx;
                o_ram_din    = r_wdata;
                o_ram_we     = 1'b1;
            end
            S_DONE: begin
                // no grant here, so a still-held request is not taken twice
                w_next_state = S_IDLE;
                if (r_owner_dbg) begin
                    bus.o_dbg_done = 1'b1;
                end else begin
                    w_mem_done    = 1'b1;
                    bus.o_mem_err = r_err;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (i_rsta) begin
            w_next_state   = S_IDLE;
            o_ram_addr     = '0;
            o_ram_din      = '0;
            o_ram_we       = 1'b0;
            o_ram_en       = 1'b0;
            o_ram_regce    = 1'b0;
            w_mem_done     = 1'b0;
            bus.o_mem_err  = 1'b0;
            bus.o_dbg_done = 1'b0;
        end
    end

    assign bus.o_mem_done  = w_mem_done;
    assign bus.o_mem_stall = bus.i_mem_req & ~w_mem_done;
    assign bus.o_mem_rdata = r_mem_rdata;
    assign bus.o_dbg_rdata = r_dbg_rdata;
    assign o_ram_rst       = i_rsta;

    always_ff @(posedge i_clka) begin
        if (i_rsta) begin
            r_state     <= S_IDLE;
            r_owner_dbg <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_lane      <= 2'b00;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_mem_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_mem_req) begin
                        r_owner_dbg <= 1'b0;
                        r_we        <= bus.i_mem_we;
                        r_size      <= bus.i_mem_size;
                        r_unsigned  <= bus.i_mem_unsigned;
                        r_lane      <= bus.i_mem_addr[1:0];
                        r_idx       <= w_mem_idx;
                        r_wdata     <= bus.i_mem_wdata;
                        r_err       <= w_mem_err;
                        r_mem_rdata <= '0;
                    end else if (bus.i_dbg_req) begin
                        r_owner_dbg <= 1'b1;
                        r_we        <= 1'b0;
                        r_idx       <= bus.i_dbg_addr;
                        r_err       <= 1'b0;
                    end
                end
                S_RD2: begin
                    if (r_owner_dbg)
                        r_dbg_rdata <= i_ram_dout;
                    else if (r_we)
                        r_wdata     <= w_merged;
                    else
                        r_mem_rdata <= w_load;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_datos_ctrl.sv
module tb_ram_datos_ctrl;
    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic        ram_we, ram_en, ram_regce, ram_rst;

    ram_datos_ctrl_if bus();

    ram_datos_ctrl #(.RAM_WIDTH(32), .RAM_DEPTH(DEPTH)) dut (
        .i_clka     (clk),
        .i_rsta     (rst),
        .bus        (bus),
        .o_ram_addr (ram_addr),
        .o_ram_din  (ram_din),
        .o_ram_we   (ram_we),
        .o_ram_en   (ram_en),
        .o_ram_regce(ram_regce),
        .o_ram_rst  (ram_rst),
        .i_ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // BRAM: read latch on en, output register on regce (2-cycle latency)
    logic [31:0] bram [DEPTH];
    logic [31:0] bram_lat;
    always @(posedge clk) begin
        if (ram_en && ram_addr < DEPTH) bram_lat <= bram[ram_addr];
        if (ram_we && ram_addr < DEPTH) bram[ram_addr] <= ram_din;
        if (ram_regce) ram_dout <= bram_lat;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] model_mem [DEPTH];
    bit          m_busy = 0;
    int          m_k, m_L, m_wk;
    bit          m_dbg, m_read, m_err, m_chkrd;
    logic [31:0] m_rd, m_widx, m_wword;

    always @(negedge clk) begin
        logic        e_md, e_dd, e_we, e_en, e_rg;
        logic [31:0] a, idx, w, v, mask;
        int          nb, off;
        e_md = 0; e_dd = 0; e_we = 0; e_en = 0; e_rg = 0;
        if (rst) begin
            m_busy = 0;
        end else if (m_busy) begin
            m_k++;
            if (m_k == m_wk) begin e_we = 1; model_mem[m_widx] = m_wword; end
            if (m_k == 1 && m_read) e_rg = 1;
            if (m_k == m_L) begin
                m_busy = 0;
                if (m_dbg) e_dd = 1; else e_md = 1;
            end
        end else if (bus.i_mem_req || bus.i_dbg_req) begin
            m_busy = 1; m_k = 0; m_wk = -1; m_read = 0; m_err = 0; m_rd = 0; m_chkrd = 1;
            if (bus.i_mem_req) begin
                m_dbg = 0;
                a   = bus.i_mem_addr;
                nb  = 1 << bus.i_mem_size;
                off = int'(a % 4);
                idx = a / 4;
                if (bus.i_mem_size == 2'b11 || (a % nb) != 0 || idx >= DEPTH) begin
                    m_err = 1; m_L = 1;
                end else if (bus.i_mem_we) begin
                    m_chkrd = 0;
                    w = model_mem[idx];
                    for (int b = 0; b < nb; b++) w[8*(off+b) +: 8] = bus.i_mem_wdata[8*b +: 8];
                    m_widx = idx; m_wword = w;
                    if (nb == 4) begin m_L = 1; m_wk = 0; end
                    else begin m_L = 4; m_wk = 3; m_read = 1; end
                end else begin
                    m_read = 1; m_L = 3;
                    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
                    v = (model_mem[idx] >> (8*off)) & mask;
                    if (!bus.i_mem_unsigned && nb < 4 && v[8*nb-1]) v = v | ~mask;
                    m_rd = v;
                end
            end else begin
                m_dbg = 1; m_read = 1; m_L = 3;
                m_rd = model_mem[bus.i_dbg_addr];
            end
            if (m_read) e_en = 1;
            if (m_wk == 0) begin e_we = 1; model_mem[m_widx] = m_wword; end
        end

        chk("mem_done", {31'd0, bus.o_mem_done}, {31'd0, e_md});
        chk("dbg_done", {31'd0, bus.o_dbg_done}, {31'd0, e_dd});
        chk("ram_we",   {31'd0, ram_we},    {31'd0, e_we});
        chk("ram_en",   {31'd0, ram_en},    {31'd0, e_en});
        chk("ram_regce",{31'd0, ram_regce}, {31'd0, e_rg});
        chk("ram_rst",  {31'd0, ram_rst},   {31'd0, rst});
        chk("stall",    {31'd0, bus.o_mem_stall}, {31'd0, bus.i_mem_req & ~e_md});
        if (e_md) begin
            chk("mem_err", {31'd0, bus.o_mem_err}, {31'd0, m_err});
            if (m_chkrd) chk("mem_rdata", bus.o_mem_rdata, m_rd);
        end
        if (e_dd) chk("dbg_rdata", bus.o_dbg_rdata, m_rd);
        if (e_we) begin
            chk("ram_addr_wr", ram_addr, m_widx);
            chk("ram_din", ram_din, m_wword);
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic mem_op(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int t; bit seen; logic [31:0] rd; logic er;
        bus.i_mem_req = 1; bus.i_mem_we = we; bus.i_mem_size = sz;
        bus.i_mem_unsigned = uns; bus.i_mem_addr = a; bus.i_mem_wdata = wd;
        t = 0; seen = 0; rd = 0; er = 0;
        while (!seen && t < 20) begin
            @(negedge clk);
            if (bus.o_mem_done) begin seen = 1; rd = bus.o_mem_rdata; er = bus.o_mem_err; end
            else t++;
        end
        @(posedge clk); #1;
        bus.i_mem_req = 0;
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: no done within 20 cycles", nm);
        end else begin
            chk({nm, "_lat"}, t, exp_lat);
            chk({nm, "_err"}, {31'd0, er}, {31'd0, exp_err});
            if (!we || exp_err) chk({nm, "_rdata"}, rd, exp_rd);
        end
    endtask

    initial begin
        int t, md, dd;
        logic [31:0] dv;
        for (int i = 0; i < DEPTH; i++) begin
            bram[i] = 32'h1000_0000 + i;
            model_mem[i] = 32'h1000_0000 + i;
        end
        bram[1] = 32'h1122_3344; model_mem[1] = 32'h1122_3344;
        bram[3] = 32'hCAFE_F00D; model_mem[3] = 32'hCAFE_F00D;
        ram_dout = 0; bram_lat = 0;
        rst = 1;
        bus.i_mem_req = 0; bus.i_mem_we = 0; bus.i_mem_size = 0; bus.i_mem_unsigned = 0;
        bus.i_mem_addr = 0; bus.i_mem_wdata = 0; bus.i_dbg_req = 0; bus.i_dbg_addr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_rdata", bus.o_mem_rdata, 32'h0);
        chk("rst_dbg_rdata", bus.o_dbg_rdata, 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        mem_op("sb5",    1, 2'b00, 0, 32'h5, 32'hAB, 32'h0, 0, 4);
        mem_op("lw4",    0, 2'b10, 0, 32'h4, 0, 32'h1122_AB44, 0, 3);
        mem_op("lb5",    0, 2'b00, 0, 32'h5, 0, 32'hFFFF_FFAB, 0, 3);
        mem_op("lbu5",   0, 2'b00, 1, 32'h5, 0, 32'h0000_00AB, 0, 3);
        mem_op("lh6",    0, 2'b01, 0, 32'h6, 0, 32'h0000_1122, 0, 3);
        mem_op("lh4",    0, 2'b01, 0, 32'h4, 0, 32'hFFFF_AB44, 0, 3);
        mem_op("lhu4",   0, 2'b01, 1, 32'h4, 0, 32'h0000_AB44, 0, 3);
        mem_op("lb4",    0, 2'b00, 0, 32'h4, 0, 32'h0000_0044, 0, 3);
        mem_op("sw8",    1, 2'b10, 0, 32'h8, 32'hDEAD_BEEF, 32'h0, 0, 1);
        mem_op("lw8",    0, 2'b10, 0, 32'h8, 0, 32'hDEAD_BEEF, 0, 3);
        mem_op("shA",    1, 2'b01, 0, 32'hA, 32'h1234_5566, 32'h0, 0, 4);
        mem_op("lw8b",   0, 2'b10, 0, 32'h8, 0, 32'h5566_BEEF, 0, 3);
        mem_op("lw2err", 0, 2'b10, 0, 32'h2, 0, 32'h0, 1, 1);
        mem_op("sw_oor", 1, 2'b10, 0, 32'h2000, 32'h5555_5555, 32'h0, 1, 1);
        mem_op("lh3err", 0, 2'b01, 0, 32'h3, 0, 32'h0, 1, 1);
        mem_op("sz3err", 0, 2'b11, 0, 32'h4, 0, 32'h0, 1, 1);
        mem_op("lw_last",0, 2'b10, 0, 32'h1FFC, 0, 32'h1000_07FF, 0, 3);

        // MEM and debug in the same cycle: MEM first, debug in the following IDLE
        bus.i_mem_req = 1; bus.i_mem_we = 0; bus.i_mem_size = 2'b10; bus.i_mem_addr = 32'hC;
        bus.i_dbg_req = 1; bus.i_dbg_addr = 32'd3;
        t = 0; md = -1; dd = -1; dv = 0;
        while ((md < 0 || dd < 0) && t < 30) begin
            @(negedge clk);
            if (bus.o_mem_done) md = t;
            if (bus.o_dbg_done) begin dd = t; dv = bus.o_dbg_rdata; end
            @(posedge clk); #1;
            if (md >= 0) bus.i_mem_req = 0;
            if (dd >= 0) bus.i_dbg_req = 0;
            t++;
        end
        bus.i_mem_req = 0; bus.i_dbg_req = 0;
        chk("arb_mem_lat", md, 3);
        chk("arb_dbg_lat", dd, 7);
        chk("arb_dbg_rdata", dv, 32'hCAFE_F00D);

        // Reset during the write cycle of an sb: nothing written, no done
        bus.i_mem_req = 1; bus.i_mem_we = 1; bus.i_mem_size = 2'b00;
        bus.i_mem_addr = 32'h5; bus.i_mem_wdata = 32'h77;
        repeat (3) @(posedge clk);
        #1;
        rst = 1; bus.i_mem_req = 0;
        @(negedge clk);
        chk("rst_wr_we", {31'd0, ram_we}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_wr_done", {31'd0, bus.o_mem_done}, 32'd0);
        @(posedge clk); #1;
        mem_op("lw4_after_rst", 0, 2'b10, 0, 32'h4, 0, 32'h1122_AB44, 0, 3);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
